mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory request port between the I-cache (read-only) and the D-cache (read/write).
//  Sits between both cache miss/refill ports and the memory model; one transaction in flight at a time.
//  Round-robin grant; a watchdog flags memory transactions that never complete.
// PARAMETERS
//  ADDR_W      32    address width
//  DATA_W      32    data width
//  TIMEOUT     255   cycles in BUSY before err_timeout asserts (counter width = clog2(TIMEOUT+1))
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, synchronous, active-high
//  i_req_valid   in   1       I-cache request; held with i_req_addr stable until i_req_ready
//  i_req_addr    in   ADDR_W  I-cache address
//  i_req_ready   out  1       one-cycle completion pulse to I-cache
//  i_rd_data     out  DATA_W  read data to I-cache, valid while i_req_ready=1
//  d_req_valid   in   1       D-cache request; held with addr/wr/wdata stable until d_req_ready
//  d_req_addr    in   ADDR_W  D-cache address
//  d_req_wr      in   1       1=write, 0=read
//  d_wr_data     in   DATA_W  D-cache write data
//  d_req_ready   out  1       one-cycle completion pulse to D-cache
//  d_rd_data     out  DATA_W  read data to D-cache, valid while d_req_ready=1
//  mem_req_valid out  1       request to memory (registered)
//  mem_req_addr  out  ADDR_W  latched address (registered)
//  mem_req_wr    out  1       latched write flag (registered)
//  mem_wr_data   out  DATA_W  latched write data (registered)
//  mem_req_ready in   1       memory completion pulse
//  mem_rd_data   in   DATA_W  memory read data, valid with mem_req_ready
//  err_timeout   out  1       sticky watchdog error
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=D, all outputs 0, watchdog counter 0, err_timeout 0.
//  FSM: IDLE -> BUSY_I | BUSY_D -> DONE -> IDLE.
//  IDLE: only i valid -> BUSY_I; only d valid -> BUSY_D; both valid -> grant the one NOT equal to last_grant.
//    On grant: latch addr/wr/wdata into mem_req_* (I grant: mem_req_wr=0, mem_wr_data=0),
//    set mem_req_valid=1, update last_grant.
//  BUSY_x: hold mem_req_* stable. On mem_req_ready=1: x_req_ready=1 in the same cycle (combinational),
//    x_rd_data=mem_rd_data, mem_req_valid drops to 0 next edge, -> DONE.
//  DONE: one bubble cycle so the requester can deassert valid; no grant; -> IDLE.
//  Latency: req valid at IDLE edge N -> mem_req_valid at N+1; minimum req->ready = 2 cycles.
//  x_req_ready is never asserted outside BUSY_x; the non-owner's ready is 0 and its rd_data is 0.
//  mem_req_ready seen in IDLE/DONE is ignored.
//  Requester dropping valid while in BUSY: transaction still completes; the ready pulse is still issued.
//  Watchdog: counts cycles in BUSY_x, cleared on entry; at count==TIMEOUT, err_timeout<=1 (sticky until rst).
//    FSM keeps waiting.
//  rst mid-transaction: return to IDLE next edge, mem_req_valid=0, no ready pulse issued.
// TESTING
//  I-only read addr 0x100, mem ready 3 cycles after valid -> mem_req_addr=0x100, wr=0;
//    i_req_ready 1 cycle, i_rd_data=mem data.
//  D-only write addr 0x200 data 0xDEADBEEF -> mem_req_wr=1, mem_wr_data=0xDEADBEEF;
//    d_req_ready pulses once; i_req_ready stays 0.
//  Both valid after reset (last_grant=D) -> I served first, then D after DONE;
//    repeat with both always valid -> strict I,D,I,D alternation.
//  mem_req_ready pulsed while IDLE -> no ready to either cache, state unchanged.
//  Memory never responds, TIMEOUT=8 -> err_timeout=1 after 8 BUSY cycles, stays 1; cleared only by rst.
//  rst asserted during BUSY_D -> next cycle mem_req_valid=0, state IDLE, d_req_ready never pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory request port between the I-cache (read-only) and the
//   D-cache (read/write). One transaction in flight at a time, round-robin
//   grant when both request together, sticky watchdog for transactions that
//   never complete.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_req_valid/i_req_addr        I-cache request (held until i_req_ready)
//   i_req_ready/i_rd_data         I-cache completion pulse and read data
//   d_req_valid/d_req_addr/
//   d_req_wr/d_wr_data            D-cache request (held until d_req_ready)
//   d_req_ready/d_rd_data         D-cache completion pulse and read data
//   mem_req_valid/mem_req_addr/
//   mem_req_wr/mem_wr_data        registered request to memory
//   mem_req_ready/mem_rd_data     memory completion pulse and read data
//   err_timeout                   sticky watchdog error
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic [DATA_W-1:0] i_rd_data,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_wr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_req_ready,
    output logic [DATA_W-1:0] d_rd_data,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_req_ready,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              err_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    state_t             state_q, state_d;
    grant_t             last_grant_q, last_grant_d;
    mem_req_t           req_q, req_d;
    logic               req_valid_q, req_valid_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;
    logic               err_q, err_d;
    logic               busy;
    logic               grant_i;

    // Arbitration, request latching, FSM sequencing and watchdog
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        req_valid_d  = req_valid_q;
        wdog_d       = wdog_q;
        err_d        = err_q;

        busy    = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
        // I wins when alone, or when both ask and D had the previous grant
        grant_i = i_req_valid && (!d_req_valid || (last_grant_q == GRANT_D));

        case (state_q)
            ST_IDLE: begin
                if (grant_i) begin
                    state_d      = ST_BUSY_I;
                    last_grant_d = GRANT_I;
                    req_d.addr   = i_req_addr;
                    req_d.wr     = 1'b0;
                    req_d.wdata  = '0;
                    req_valid_d  = 1'b1;
                    wdog_d       = '0;
                end else if (d_req_valid) begin
                    state_d      = ST_BUSY_D;
                    last_grant_d = GRANT_D;
                    req_d.addr   = d_req_addr;
                    req_d.wr     = d_req_wr;
                    req_d.wdata  = d_wr_data;
                    req_valid_d  = 1'b1;
                    wdog_d       = '0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_req_ready) begin
                    state_d     = ST_DONE;
                    req_valid_d = 1'b0;
                end
            end
            ST_DONE: begin
                // Bubble so the served requester can drop valid before re-arbitration
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog saturates at TIMEOUT; the FSM keeps waiting on memory
        if (busy) begin
            if (wdog_q == CNT_W'(TIMEOUT)) begin
                err_d = 1'b1;
            end else begin
                wdog_d = wdog_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_D;
            req_q        <= '0;
            req_valid_q  <= 1'b0;
            wdog_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            req_valid_q  <= req_valid_d;
            wdog_q       <= wdog_d;
            err_q        <= err_d;
        end
    end

    // Completion is passed straight through in the memory-ready cycle; reset suppresses it
    assign i_req_ready = (state_q == ST_BUSY_I) && mem_req_ready && !rst;
    assign d_req_ready = (state_q == ST_BUSY_D) && mem_req_ready && !rst;
    assign i_rd_data   = i_req_ready ? mem_rd_data : '0;
    assign d_rd_data   = d_req_ready ? mem_rd_data : '0;

    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_q.addr;
    assign mem_req_wr    = req_q.wr;
    assign mem_wr_data   = req_q.wdata;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: drivers for both caches, a randomized memory
// responder, and a scoreboard monitor checking every memory request and every
// cache completion against a grant-order model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk;
    logic          rst;
    logic          i_req_valid;
    logic [AW-1:0] i_req_addr;
    logic          i_req_ready;
    logic [DW-1:0] i_rd_data;
    logic          d_req_valid;
    logic [AW-1:0] d_req_addr;
    logic          d_req_wr;
    logic [DW-1:0] d_wr_data;
    logic          d_req_ready;
    logic [DW-1:0] d_rd_data;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_req_ready;
    logic [DW-1:0] mem_rd_data;
    logic          err_timeout;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_ready  (i_req_ready),
        .i_rd_data    (i_rd_data),
        .d_req_valid  (d_req_valid),
        .d_req_addr   (d_req_addr),
        .d_req_wr     (d_req_wr),
        .d_wr_data    (d_wr_data),
        .d_req_ready  (d_req_ready),
        .d_rd_data    (d_rd_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_wr   (mem_req_wr),
        .mem_wr_data  (mem_wr_data),
        .mem_req_ready(mem_req_ready),
        .mem_rd_data  (mem_rd_data),
        .err_timeout  (err_timeout)
    );

    typedef struct packed {
        logic          owner;   // 0 = I-cache, 1 = D-cache
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] resp_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic last_m   = 1'b1;       // model of last grant, D after reset

    int   lat_min    = 0;
    int   lat_max    = 4;
    bit   mem_enable = 1'b1;
    bit   spurious   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory responder: random latency, random read data, one-cycle ready pulse
    initial begin
        bit          busy_m;
        int          lat;
        int          wcnt;
        logic [DW-1:0] rd;
        busy_m = 1'b0;
        lat = 0;
        wcnt = 0;
        mem_req_ready = 1'b0;
        mem_rd_data   = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
            mem_rd_data   = '0;
            if (!mem_req_valid) busy_m = 1'b0;
            if (mem_req_valid && mem_enable) begin
                if (!busy_m) begin
                    busy_m = 1'b1;
                    lat    = $urandom_range(lat_max, lat_min);
                    wcnt   = 0;
                end
                if (wcnt == lat) begin
                    rd            = $urandom;
                    mem_req_ready = 1'b1;
                    mem_rd_data   = rd;
                    resp_q.push_back(rd);
                    busy_m        = 1'b0;
                end else begin
                    wcnt++;
                end
            end else if (!mem_req_valid && spurious) begin
                mem_req_ready = 1'b1;
                mem_rd_data   = $urandom;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        bit   prev_valid;
        bit   prev_ready;
        bit   outstanding;
        exp_t cur;
        logic [DW-1:0] rexp;
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
        outstanding = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("ready_during_rst", 32'({i_req_ready, d_req_ready}), 32'd0);
                outstanding = 1'b0;
                prev_ready  = 1'b0;
                prev_valid  = mem_req_valid;
            end else begin
                if (prev_ready) chk("mem_valid_drop", 32'(mem_req_valid), 32'd0);
                if (mem_req_valid && !prev_valid) begin
                    chk("prev_txn_done", 32'(outstanding), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_request", 32'(1), 32'(0));
                    end else begin
                        cur = exp_q.pop_front();
                        chk("req_addr", mem_req_addr, cur.addr);
                        chk("req_wr", 32'(mem_req_wr), 32'(cur.wr));
                        chk("req_wdata", mem_wr_data, cur.wdata);
                        outstanding = 1'b1;
                    end
                end else if (mem_req_valid && outstanding) begin
                    chk("req_hold", {mem_req_addr[30:0], mem_req_wr} ^ mem_wr_data,
                        {cur.addr[30:0], cur.wr} ^ cur.wdata);
                end
                prev_valid = mem_req_valid;
                prev_ready = i_req_ready || d_req_ready;
                if (i_req_ready || d_req_ready) begin
                    chk("single_ready", 32'(i_req_ready && d_req_ready), 32'd0);
                    chk("ready_outstanding", 32'(outstanding), 32'd1);
                    chk("ready_owner", 32'(d_req_ready), 32'(cur.owner));
                    rexp = (resp_q.size() != 0) ? resp_q.pop_front() : 32'hxxxx_xxxx;
                    if (d_req_ready) begin
                        chk("d_rd_data", d_rd_data, rexp);
                        chk("i_rd_data_idle", i_rd_data, 32'd0);
                    end else begin
                        chk("i_rd_data", i_rd_data, rexp);
                        chk("d_rd_data_idle", d_rd_data, 32'd0);
                    end
                    outstanding = 1'b0;
                end
            end
        end
    end

    function automatic exp_t mk_exp(input logic owner);
        exp_t e;
        e.owner = owner;
        e.addr  = owner ? d_req_addr : i_req_addr;
        e.wr    = owner ? d_req_wr : 1'b0;
        e.wdata = (owner && d_req_wr) ? d_wr_data : (owner ? d_wr_data : '0);
        return e;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_m = 1'b1;
    endtask

    // One round: the selected requesters raise valid together from IDLE
    task automatic run_round(input bit want_i, input bit want_d, input logic [AW-1:0] ia,
                             input logic [AW-1:0] da, input logic dwr, input logic [DW-1:0] dd);
        bit i_pend, d_pend, seen, ir, dr;
        int cyc;
        @(posedge clk);
        #1;
        i_req_valid = want_i;
        i_req_addr  = ia;
        d_req_valid = want_d;
        d_req_addr  = da;
        d_req_wr    = dwr;
        d_wr_data   = dd;
        if (want_i && want_d) begin
            exp_q.push_back(mk_exp(!last_m));
            exp_q.push_back(mk_exp(last_m));
        end else if (want_i) begin
            exp_q.push_back(mk_exp(1'b0));
            last_m = 1'b0;
        end else if (want_d) begin
            exp_q.push_back(mk_exp(1'b1));
            last_m = 1'b1;
        end
        i_pend = want_i;
        d_pend = want_d;
        seen = 1'b0;
        cyc = 0;
        while ((i_pend || d_pend) && cyc < 60) begin
            @(negedge clk);
            ir = i_req_ready;
            dr = d_req_ready;
            if (!seen && mem_req_valid) begin
                seen = 1'b1;
                chk("grant_latency", 32'(cyc), 32'd1);
            end
            @(posedge clk);
            #1;
            if (ir) begin
                i_pend = 1'b0;
                i_req_valid = 1'b0;
                i_req_addr = $urandom;
            end
            if (dr) begin
                d_pend = 1'b0;
                d_req_valid = 1'b0;
                d_req_addr = $urandom;
            end
            cyc++;
        end
        if (i_pend || d_pend) begin
            chk("round_complete", 32'({i_pend, d_pend}), 32'd0);
            i_req_valid = 1'b0;
            d_req_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for the request to reach memory
    task automatic wait_mem_valid(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mem_req_valid && k < 10);
        chk(name, 32'(mem_req_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        d_req_valid = 1'b0;
        d_req_addr  = '0;
        d_req_wr    = 1'b0;
        d_wr_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_addr", mem_req_addr, 32'd0);
        chk("rst_mem_wr", 32'(mem_req_wr), 32'd0);
        chk("rst_mem_wdata", mem_wr_data, 32'd0);
        chk("rst_readies", 32'({i_req_ready, d_req_ready}), 32'd0);
        chk("rst_i_rd_data", i_rd_data, 32'd0);
        chk("rst_d_rd_data", d_rd_data, 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // I-only read, then D-only write, fixed latency
        lat_min = 2;
        lat_max = 2;
        run_round(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        run_round(1'b0, 1'b1, 32'h0, 32'h200, 1'b1, 32'hDEADBEEF);

        // Both after reset: I first, then strict alternation
        lat_min = 0;
        lat_max = 3;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            run_round(1'b1, 1'b1, 32'h1000 + 32'(r), 32'h2000 + 32'(r), 1'(r), $urandom);
        end

        // Spurious memory ready while IDLE
        @(posedge clk);
        #1;
        spurious = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("spurious_no_ready", 32'({i_req_ready, d_req_ready}), 32'd0);
            chk("spurious_idle", 32'(mem_req_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        spurious = 1'b0;
        run_round(1'b1, 1'b0, 32'h140, 32'h0, 1'b0, 32'h0);

        // Randomized traffic
        lat_min = 0;
        lat_max = 4;
        for (int r = 0; r < 40; r++) begin
            int m;
            m = $urandom_range(3, 1);
            repeat ($urandom_range(2, 0)) @(posedge clk);
            run_round(m[0], m[1], $urandom, $urandom, 1'($urandom_range(1, 0)), $urandom);
        end
        @(negedge clk);
        chk("no_err_random", 32'(err_timeout), 32'd0);

        // Reset during BUSY_D
        mem_enable = 1'b0;
        @(posedge clk);
        #1;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h480;
        d_req_wr    = 1'b1;
        d_wr_data   = 32'h1234_5678;
        exp_q.push_back(mk_exp(1'b1));
        wait_mem_valid("busy_d_valid");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        d_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_m = 1'b1;
        mem_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_busy_valid", 32'(mem_req_valid), 32'd0);
            chk("rst_busy_no_ready", 32'(d_req_ready), 32'd0);
        end
        run_round(1'b1, 1'b1, 32'h500, 32'h600, 1'b0, 32'h0);

        // Watchdog: memory never answers
        mem_enable = 1'b0;
        @(posedge clk);
        #1;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h300;
        exp_q.push_back(mk_exp(1'b0));
        wait_mem_valid("wdog_valid");
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= int'(TO)) chk("err_early", 32'(err_timeout), 32'd0);
            if (k >= int'(TO) + 2) chk("err_sticky", 32'(err_timeout), 32'd1);
        end
        chk("wdog_still_waiting", 32'(mem_req_valid), 32'd1);
        do_reset();
        mem_enable = 1'b1;
        @(negedge clk);
        chk("err_cleared", 32'(err_timeout), 32'd0);
        chk("err_rst_valid", 32'(mem_req_valid), 32'd0);
        run_round(1'b0, 1'b1, 32'h0, 32'h700, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "global timeout");
    end

endmodule
